// File: rtl/sme_job_feeder.sv
// Buffers one string/pattern job, replays it to the SME as a gap-free burst, holds the result.
// Optional WAIT_RES watchdog: define SME_FEED_TIMEOUT_EN.
module sme_job_feeder #(
  parameter int STR_MAX        = 32,
  parameter int PAT_MAX        = 10,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sel,
  input  logic       in_last,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err,
  output logic       res_timeout,
  output logic [7:0] job_cnt
);
  localparam int SW = $clog2(STR_MAX);
  localparam int PW = $clog2(PAT_MAX);

  typedef enum logic [2:0] {
    LOAD, SEND_STR, SEND_PAT, KICK, WAIT_RES, RESULT
  } state_t;

  state_t r_state, w_state_n;

  logic [7:0] r_sbuf [STR_MAX];
  logic [7:0] r_pbuf [PAT_MAX];
  logic [5:0] r_str_cnt, r_pat_cnt, r_idx, w_idx_n;
  logic       r_err, r_seen_pat, r_has_lit, r_rdy;
  logic [7:0] r_cd, w_cd_n;
  logic       r_is, w_is_n, r_ip, w_ip_n;
  logic       r_rv, r_rm, r_re, r_rt;
  logic [4:0] r_ri;
  logic [7:0] r_job;

  logic       w_acc, w_psel, w_sdrop, w_pdrop, w_swr, w_pwr;
  logic       w_anchor, w_lit, w_berr;
  logic [7:0] w_p0;
  logic       w_skip, w_cap, w_done;

`ifdef SME_FEED_TIMEOUT_EN
  logic [15:0] r_tmo;
  logic        w_tmo;
  assign w_tmo = (r_state == WAIT_RES) & ~sme_valid &
                 (r_tmo == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= 16'd0;
    end else if (r_state == WAIT_RES) begin
      r_tmo <= r_tmo + 16'd1;
    end else begin
      r_tmo <= 16'd0;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^16'(TIMEOUT_CYCLES);
`endif

  // in_last forces the byte into the pattern buffer
  assign w_psel   = in_sel | in_last;
  assign w_acc    = in_valid & r_rdy;
  assign w_sdrop  = r_seen_pat | (r_str_cnt == 6'(STR_MAX));
  assign w_pdrop  = (r_pat_cnt == 6'(PAT_MAX));
  assign w_swr    = w_acc & ~w_psel & ~w_sdrop;
  assign w_pwr    = w_acc & w_psel & ~w_pdrop;
  assign w_anchor = (in_data == 8'h5E) | (in_data == 8'h24);
  assign w_lit    = r_has_lit | (w_pwr & ~w_anchor);
  assign w_berr   = w_acc & ((~w_psel & w_sdrop) |
                    (w_psel & w_pdrop) | (in_last & ~in_sel));
  // first pattern byte may be arriving this very cycle
  assign w_p0     = (r_pat_cnt == 6'd0) ? in_data : r_pbuf[0];

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cd_n    = 8'd0;
    w_is_n    = 1'b0;
    w_ip_n    = 1'b0;
    w_skip    = 1'b0;
    w_cap     = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      LOAD: begin
        if (w_acc & in_last) begin
          if (!w_lit) begin
            w_state_n = RESULT;
            w_skip    = 1'b1;
          end else if (r_str_cnt != 6'd0) begin
            w_state_n = SEND_STR;
            w_cd_n    = r_sbuf[0];
            w_is_n    = 1'b1;
            w_idx_n   = 6'd1;
          end else begin
            w_state_n = SEND_PAT;
            w_cd_n    = w_p0;
            w_ip_n    = 1'b1;
            w_idx_n   = 6'd1;
          end
        end
      end
      SEND_STR: begin
        if (r_idx == r_str_cnt) begin
          w_state_n = SEND_PAT;
          w_cd_n    = r_pbuf[0];
          w_ip_n    = 1'b1;
          w_idx_n   = 6'd1;
        end else begin
          w_cd_n  = r_sbuf[r_idx[SW-1:0]];
          w_is_n  = 1'b1;
          w_idx_n = r_idx + 6'd1;
        end
      end
      SEND_PAT: begin
        if (r_idx == r_pat_cnt) begin
          w_state_n = KICK;
        end else begin
          w_cd_n  = r_pbuf[r_idx[PW-1:0]];
          w_ip_n  = 1'b1;
          w_idx_n = r_idx + 6'd1;
        end
      end
      KICK: w_state_n = WAIT_RES;
      WAIT_RES: begin
        if (sme_valid) begin
          w_state_n = RESULT;
          w_cap     = 1'b1;
        end
`ifdef SME_FEED_TIMEOUT_EN
        else if (w_tmo) begin
          w_state_n = RESULT;
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          w_state_n = LOAD;
          w_done    = 1'b1;
        end
      end
      default: w_state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STR_MAX; i++) r_sbuf[i] <= 8'd0;
      for (int i = 0; i < PAT_MAX; i++) r_pbuf[i] <= 8'd0;
      r_str_cnt  <= 6'd0;
      r_pat_cnt  <= 6'd0;
      r_idx      <= 6'd0;
      r_err      <= 1'b0;
      r_seen_pat <= 1'b0;
      r_has_lit  <= 1'b0;
      r_rdy      <= 1'b0;
      r_cd       <= 8'd0;
      r_is       <= 1'b0;
      r_ip       <= 1'b0;
      r_rv       <= 1'b0;
      r_rm       <= 1'b0;
      r_ri       <= 5'd0;
      r_re       <= 1'b0;
      r_rt       <= 1'b0;
      r_job      <= 8'd0;
    end else begin
      r_rdy <= (w_state_n == LOAD);
      r_idx <= w_idx_n;
      r_cd  <= w_cd_n;
      r_is  <= w_is_n;
      r_ip  <= w_ip_n;
      if (w_swr) begin
        r_sbuf[r_str_cnt[SW-1:0]] <= in_data;
        r_str_cnt <= r_str_cnt + 6'd1;
      end
      if (w_pwr) begin
        r_pbuf[r_pat_cnt[PW-1:0]] <= in_data;
        r_pat_cnt <= r_pat_cnt + 6'd1;
      end
      if (w_acc & w_psel) r_seen_pat <= 1'b1;
      if (w_pwr & ~w_anchor) r_has_lit <= 1'b1;
      if (w_berr) r_err <= 1'b1;
      if (w_skip) begin
        r_rv <= 1'b1;
        r_re <= 1'b1;
      end
      if (w_cap) begin
        r_rv <= 1'b1;
        r_rm <= sme_match;
        r_ri <= sme_match ? sme_match_index : 5'd0;
        r_re <= r_err;
      end
`ifdef SME_FEED_TIMEOUT_EN
      if (w_tmo) begin
        r_rv <= 1'b1;
        r_rt <= 1'b1;
        r_re <= r_err;
      end
`endif
      if (w_done) begin
        r_rv       <= 1'b0;
        r_rm       <= 1'b0;
        r_ri       <= 5'd0;
        r_re       <= 1'b0;
        r_rt       <= 1'b0;
        r_job      <= r_job + 8'd1;
        r_str_cnt  <= 6'd0;
        r_pat_cnt  <= 6'd0;
        r_err      <= 1'b0;
        r_seen_pat <= 1'b0;
        r_has_lit  <= 1'b0;
      end
    end
  end

  assign in_ready      = r_rdy;
  assign sme_chardata  = r_cd;
  assign sme_isstring  = r_is;
  assign sme_ispattern = r_ip;
  assign res_valid     = r_rv;
  assign res_match     = r_rm;
  assign res_index     = r_ri;
  assign res_err       = r_re;
  assign res_timeout   = r_rt;
  assign job_cnt       = r_job;

endmodule

// File: tb/tb_sme_job_feeder.sv
// Bench for sme_job_feeder: SME stream scoreboard plus a small SME result model.
// Build with SME_FEED_TIMEOUT_EN to include the watchdog scenario.
module tb_sme_job_feeder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       in_sel = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] sme_chardata;
  logic       sme_isstring, sme_ispattern;
  logic       sme_valid;
  logic       sme_match = 1'b0;
  logic [4:0] sme_match_index = 5'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_match, res_err, res_timeout;
  logic [4:0] res_index;
  logic [7:0] job_cnt;

  int tests = 0;
  int fails = 0;
  int exp_jobs = 0;

  logic [9:0] exp_q[$];
  logic [9:0] e;
  int         n_str, n_pat, m_cnt;
  bit         gap, burst_ended, prev_strobe, m_silent;
  logic       m_match;
  logic [4:0] m_idx;
  logic       mdl_v = 1'b0;
  logic       tb_v = 1'b0;

  assign sme_valid = mdl_v | tb_v;

  always #5 clk = ~clk;

  sme_job_feeder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last),
    .sme_chardata(sme_chardata), .sme_isstring(sme_isstring),
    .sme_ispattern(sme_ispattern), .sme_valid(sme_valid),
    .sme_match(sme_match), .sme_match_index(sme_match_index),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_match(res_match), .res_index(res_index), .res_err(res_err),
    .res_timeout(res_timeout), .job_cnt(job_cnt)
  );

  // stream monitor and SME model: answers 3 cycles after the kick
  always @(negedge clk) begin
    mdl_v = 1'b0;
    if (reset) begin
      prev_strobe = 1'b0;
      m_cnt = 0;
    end else begin
      if (sme_isstring | sme_ispattern) begin
        if (sme_isstring) n_str++;
        if (sme_ispattern) n_pat++;
        if (burst_ended) gap = 1'b1;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream: unexpected strobe is=%b ip=%b ch=%h",
                   sme_isstring, sme_ispattern, sme_chardata);
        end else begin
          e = exp_q.pop_front();
          if ({sme_isstring, sme_ispattern, sme_chardata} !== e) begin
            fails++;
            $display("FAIL stream: got %b_%b_%h want %b_%b_%h",
                     sme_isstring, sme_ispattern, sme_chardata,
                     e[9], e[8], e[7:0]);
          end
        end
      end else if (prev_strobe) begin
        burst_ended = 1'b1;
        tests++;
        if (sme_chardata !== 8'd0) begin
          fails++;
          $display("FAIL kick: chardata=%h want 00", sme_chardata);
        end
        if (!m_silent) m_cnt = 3;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mdl_v = 1'b1;
          sme_match = m_match;
          sme_match_index = m_idx;
        end
      end
      prev_strobe = sme_isstring | sme_ispattern;
    end
  end

  task automatic job_begin(input logic m, input logic [4:0] ix);
    n_str = 0;
    n_pat = 0;
    gap = 1'b0;
    burst_ended = 1'b0;
    exp_q.delete();
    m_match = m;
    m_idx = ix;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s,
                           input logic l, input bit push);
    int n = 0;
    if (push) exp_q.push_back({~s, s, d});
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_sel = s;
    in_last = l;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_byte: in_ready=%b want 1", in_ready);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic await_res(input string nm, output bit ok);
    int n = 0;
    while (res_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (res_valid === 1'b1);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: res_valid=%b after %0d cycles want 1", nm, res_valid, n);
    end
  endtask

  task automatic take_res(input logic m, input logic [4:0] ix, input logic er,
                          input logic t, input string nm);
    tests++;
    if ({res_match, res_index, res_err, res_timeout} !== {m, ix, er, t}) begin
      fails++;
      $display("FAIL %s result: got m=%b i=%0d e=%b t=%b want m=%b i=%0d e=%b t=%b",
               nm, res_match, res_index, res_err, res_timeout, m, ix, er, t);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    exp_jobs++;
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0 || job_cnt !== 8'(exp_jobs) || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s release: rv=%b cnt=%0d rdy=%b want rv=0 cnt=%0d rdy=1",
               nm, res_valid, job_cnt, in_ready, exp_jobs);
    end
  endtask

  task automatic check_burst(input int es, input int ep, input string nm);
    tests++;
    if (n_str != es || n_pat != ep || gap || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s burst: str=%0d pat=%0d gap=%b left=%0d want str=%0d pat=%0d gap=0 left=0",
               nm, n_str, n_pat, gap, exp_q.size(), es, ep);
    end
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if ({in_ready, sme_isstring, sme_ispattern, sme_chardata, res_valid,
         res_match, res_index, res_err, res_timeout, job_cnt} !== '0) begin
      fails++;
      $display("FAIL reset: outputs nonzero rdy=%b rv=%b cnt=%0d ch=%h",
               in_ready, res_valid, job_cnt, sme_chardata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || job_cnt !== 8'd0) begin
      fails++;
      $display("FAIL post_reset: rdy=%b cnt=%0d want rdy=1 cnt=0", in_ready, job_cnt);
    end
    tb_v = 1'b1;
    @(negedge clk);
    tb_v = 1'b0;
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL stray_valid: res_valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_basic;
    string s = "ab cd";
    bit ok;
    job_begin(1'b1, 5'd3);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, 1'b0, 1'b1);
    send_byte(8'h63, 1'b1, 1'b0, 1'b1);
    send_byte(8'h64, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    tests++;
    if (sme_isstring !== 1'b1 || sme_chardata !== 8'h61) begin
      fails++;
      $display("FAIL latency: is=%b ch=%h want is=1 ch=61", sme_isstring, sme_chardata);
    end
    await_res("basic", ok);
    check_burst(5, 2, "basic");
    if (ok) take_res(1'b1, 5'd3, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_pattern_only;
    bit ok;
    job_begin(1'b0, 5'd7);
    send_byte(8'h5E, 1'b1, 1'b0, 1'b1);
    send_byte(8'h78, 1'b1, 1'b0, 1'b1);
    send_byte(8'h24, 1'b1, 1'b1, 1'b1);
    await_res("pat_only", ok);
    check_burst(0, 3, "pat_only");
    if (ok) take_res(1'b0, 5'd0, 1'b0, 1'b0, "pat_only");
  endtask

  task automatic test_gappy;
    string s = "hello";
    bit ok;
    job_begin(1'b1, 5'd2);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    send_byte(8'h6C, 1'b1, 1'b1, 1'b1);
    await_res("gappy", ok);
    check_burst(5, 1, "gappy");
    if (ok) take_res(1'b1, 5'd2, 1'b0, 1'b0, "gappy");
  endtask

  task automatic test_overflow;
    bit ok;
    job_begin(1'b1, 5'd5);
    for (int i = 0; i < 34; i++)
      send_byte(8'(8'h41 + (i % 26)), 1'b0, 1'b0, i < 32);
    send_byte(8'h61, 1'b1, 1'b1, 1'b1);
    await_res("overflow", ok);
    check_burst(32, 1, "overflow");
    if (ok) take_res(1'b1, 5'd5, 1'b1, 1'b0, "overflow");
  endtask

  task automatic test_order_err;
    bit ok;
    job_begin(1'b0, 5'd9);
    send_byte(8'h71, 1'b0, 1'b0, 1'b1);
    send_byte(8'h7A, 1'b1, 1'b0, 1'b1);
    send_byte(8'h77, 1'b0, 1'b0, 1'b0);
    send_byte(8'h7A, 1'b1, 1'b1, 1'b1);
    await_res("order", ok);
    check_burst(1, 2, "order");
    if (ok) take_res(1'b0, 5'd0, 1'b1, 1'b0, "order");
  endtask

  task automatic test_no_literal;
    bit ok;
    job_begin(1'b1, 5'd1);
    send_byte(8'h61, 1'b0, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0, 1'b0);
    send_byte(8'h5E, 1'b1, 1'b0, 1'b0);
    send_byte(8'h24, 1'b1, 1'b1, 1'b0);
    await_res("no_lit", ok);
    check_burst(0, 0, "no_lit");
    if (ok) take_res(1'b0, 5'd0, 1'b1, 1'b0, "no_lit");
  endtask

  task automatic test_backpressure;
    bit ok;
    job_begin(1'b1, 5'd0);
    send_byte(8'h6B, 1'b0, 1'b0, 1'b1);
    send_byte(8'h6B, 1'b1, 1'b1, 1'b1);
    await_res("bp", ok);
    if (ok) begin
      in_valid = 1'b1;
      in_data = 8'h5A;
      in_sel = 1'b1;
      in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        tests++;
        if ({res_valid, res_match, res_index, res_err, in_ready} !==
            {1'b1, 1'b1, 5'd0, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL bp hold %0d: rv=%b m=%b i=%0d e=%b rdy=%b want 1 1 0 0 0",
                   i, res_valid, res_match, res_index, res_err, in_ready);
        end
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      check_burst(1, 1, "bp");
      take_res(1'b1, 5'd0, 1'b0, 1'b0, "bp");
    end
  endtask

`ifdef SME_FEED_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    job_begin(1'b1, 5'd4);
    m_silent = 1'b1;
    send_byte(8'h61, 1'b1, 1'b1, 1'b1);
    await_res("timeout", ok);
    m_silent = 1'b0;
    if (ok) take_res(1'b0, 5'd0, 1'b0, 1'b1, "timeout");
  endtask
`endif

  initial begin
    m_silent = 1'b0;
    job_begin(1'b0, 5'd0);
    test_reset();
    test_basic();
    test_pattern_only();
    test_gappy();
    test_overflow();
    test_order_err();
    test_no_literal();
    test_backpressure();
`ifdef SME_FEED_TIMEOUT_EN
    test_timeout();
`endif
    test_basic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
